// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 32 x 32-bit register file with a per-register busy
// (pending write) scoreboard, a registered busy counter and a sticky error flag
// for writebacks that arrive at a register with no reservation.
//
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle writeback
// onto the read ports. In that case the read data shows wb_data and the busy
// flag reads 0. Without the macro, the read ports show stored state only.
module regfile_scoreboard (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic        busy1,
   output logic        busy2,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   output logic        issue_ready,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic [5:0]  busy_cnt,
   output logic        wb_err
);

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];
   logic [31:0] busy_q;
   logic [31:0] busy_d;
   logic [5:0]  busy_cnt_q;
   logic [5:0]  busy_cnt_d;
   logic        wb_err_q;
   logic        wb_err_d;

   logic        wb_we;
   logic        issue_set;
   logic        same_idx;
   logic        set_new;
   logic        clr_old;

   // Handshake decode. A writeback to the same index frees the slot in this
   // cycle, so it can be re-reserved without a bubble.
   always_comb begin
      wb_we       = wb_valid && (wb_rd != 5'd0);
      issue_ready = (issue_rd == 5'd0) || !busy_q[issue_rd] ||
                    (wb_valid && (wb_rd == issue_rd));
      issue_set   = issue_valid && issue_ready && (issue_rd != 5'd0);
      same_idx    = issue_set && wb_we && (issue_rd == wb_rd);
      // The counter moves only when a bit actually changes. A same-index
      // issue and writeback on a busy register leave the count untouched.
      set_new     = issue_set && !busy_q[issue_rd];
      clr_old     = wb_we && busy_q[wb_rd] && !same_idx;
   end

   // Next-state for registers, busy bits, counter and sticky error.
   always_comb begin
      regs_d     = regs_q;
      busy_d     = busy_q;
      busy_cnt_d = busy_cnt_q;
      wb_err_d   = wb_err_q;
      if (wb_we) begin
         regs_d[wb_rd] = wb_data;
         busy_d[wb_rd] = 1'b0;
         if (!busy_q[wb_rd] && !same_idx) begin
            wb_err_d = 1'b1;
         end
      end
      // The set is applied after the clear, so a same-index issue leaves the bit set.
      if (issue_set) begin
         busy_d[issue_rd] = 1'b1;
      end
      if (set_new && !clr_old && (busy_cnt_q != 6'd31)) begin
         busy_cnt_d = busy_cnt_q + 6'd1;
      end else if (clr_old && !set_new && (busy_cnt_q != 6'd0)) begin
         busy_cnt_d = busy_cnt_q - 6'd1;
      end
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
   end

   // State registers. Reset is asynchronous and active-low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
         wb_err_q   <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
         wb_err_q   <= wb_err_d;
      end
   end

   // Read ports: zero-latency, with optional writeback forwarding.
   always_comb begin
      rd1   = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
      rd2   = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
      busy1 = busy_q[rs1];
      busy2 = busy_q[rs2];
`ifdef REGFILE_BYPASS_EN
      if (wb_we && (rs1 == wb_rd)) begin
         rd1   = wb_data;
         busy1 = 1'b0;
      end
      if (wb_we && (rs2 == wb_rd)) begin
         rd2   = wb_data;
         busy2 = 1'b0;
      end
`endif
   end

   assign busy_cnt = busy_cnt_q;
   assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard. Expected values are hand-computed.
module tb_regfile_scoreboard;

   logic        clk;
   logic        reset;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        busy1;
   logic        busy2;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [5:0]  busy_cnt;
   logic        wb_err;

   int n_cmp = 0;
   int n_bad = 0;

   regfile_scoreboard dut (
      .clk         (clk),
      .reset       (reset),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd1         (rd1),
      .rd2         (rd2),
      .busy1       (busy1),
      .busy2       (busy2),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .busy_cnt    (busy_cnt),
      .wb_err      (wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      wb_valid    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b0;
      rs1         = 5'd0;
      rs2         = 5'd31;
      issue_valid = 1'b0;
      issue_rd    = 5'd0;
      wb_valid    = 1'b0;
      wb_rd       = 5'd0;
      wb_data     = 32'd0;
      #2;
      chk("rst_rd1", rd1, 32'd0);
      chk("rst_rd2", rd2, 32'd0);
      chk("rst_busy1", busy1, 1'b0);
      chk("rst_busy2", busy2, 1'b0);
      chk("rst_cnt", busy_cnt, 6'd0);
      chk("rst_err", wb_err, 1'b0);
      // Activity while held in reset must be ignored.
      issue_valid = 1'b1; issue_rd = 5'd4; wb_valid = 1'b1; wb_rd = 5'd31; wb_data = 32'hFFFF0000;
      step(); step();
      chk("rst_hold_cnt", busy_cnt, 6'd0);
      chk("rst_hold_rd2", rd2, 32'd0);
      idle();
      @(negedge clk);
      reset = 1'b1;
      #1;

      // Issue 5, then re-issue 5 while busy, then writeback.
      rs1 = 5'd5;
      issue_valid = 1'b1; issue_rd = 5'd5;
      #1;
      chk("iss5_ready", issue_ready, 1'b1);
      step();
      chk("iss5_cnt", busy_cnt, 6'd1);
      chk("iss5_busy1", busy1, 1'b1);
      chk("iss5_again_ready", issue_ready, 1'b0);
      step();
      chk("iss5_again_cnt", busy_cnt, 6'd1);
      issue_valid = 1'b0;
      wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
      step();
      idle();
      #1;
      chk("wb5_cnt", busy_cnt, 6'd0);
      chk("wb5_rd1", rd1, 32'hDEADBEEF);
      chk("wb5_busy1", busy1, 1'b0);
      chk("wb5_err", wb_err, 1'b0);

      // Same-cycle issue and writeback to busy register 7.
      rs1 = 5'd7;
      issue_valid = 1'b1; issue_rd = 5'd7;
      step();
      chk("iss7_cnt", busy_cnt, 6'd1);
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h12345678;
      #1;
      chk("iss7_wb_ready", issue_ready, 1'b1);
      step();
      idle();
      #1;
      chk("iss7_wb_cnt", busy_cnt, 6'd1);
      chk("iss7_wb_busy1", busy1, 1'b1);
      chk("iss7_wb_rd1", rd1, 32'h12345678);
      chk("iss7_wb_err", wb_err, 1'b0);

      // Writeback to non-busy register 9 sets the sticky error.
      rs1 = 5'd9;
      wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hA5A5A5A5;
      #1;
      chk("wb9_err_before", wb_err, 1'b0);
      step();
      idle();
      #1;
      chk("wb9_rd1", rd1, 32'hA5A5A5A5);
      chk("wb9_cnt", busy_cnt, 6'd1);
      chk("wb9_err", wb_err, 1'b1);
      step(); step();
      chk("wb9_err_held", wb_err, 1'b1);

      // Writeback to register 0 is ignored.
      rs1 = 5'd0; rs2 = 5'd0;
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
      step();
      idle();
      #1;
      chk("wb0_rd1", rd1, 32'd0);
      chk("wb0_rd2", rd2, 32'd0);
      chk("wb0_cnt", busy_cnt, 6'd1);
      chk("wb0_busy1", busy1, 1'b0);

      // Read port 2 against a same-cycle writeback to register 12.
      rs2 = 5'd12;
      wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'h11111111;
      step();
      wb_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd12;
      step();
      idle();
      #1;
      chk("iss12_cnt", busy_cnt, 6'd2);
      chk("iss12_busy2", busy2, 1'b1);
      wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'h0BADF00D;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp12_rd2", rd2, 32'h0BADF00D);
      chk("byp12_busy2", busy2, 1'b0);
`else
      chk("nobyp12_rd2", rd2, 32'h11111111);
      chk("nobyp12_busy2", busy2, 1'b1);
`endif
      step();
      idle();
      #1;
      chk("wb12_rd2", rd2, 32'h0BADF00D);
      chk("wb12_busy2", busy2, 1'b0);
      chk("wb12_cnt", busy_cnt, 6'd1);

      // Asynchronous reset pulse clears everything immediately.
      #2;
      reset = 1'b0;
      #1;
      rs1 = 5'd9; rs2 = 5'd7;
      #1;
      chk("arst_cnt", busy_cnt, 6'd0);
      chk("arst_err", wb_err, 1'b0);
      chk("arst_rd1", rd1, 32'd0);
      chk("arst_busy2", busy2, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;

      // Fill 1..20, then assert reset in the middle of the sequence.
      for (int i = 1; i <= 20; i++) begin
         issue_valid = 1'b1; issue_rd = 5'(i);
         step();
      end
      chk("fill20_cnt", busy_cnt, 6'd20);
      rs1 = 5'd20; rs2 = 5'd1;
      #1;
      chk("fill20_busy1", busy1, 1'b1);
      issue_rd = 5'd21;
      #1;
      reset = 1'b0;
      #1;
      chk("mid_rst_cnt", busy_cnt, 6'd0);
      chk("mid_rst_busy1", busy1, 1'b0);
      chk("mid_rst_busy2", busy2, 1'b0);
      step(); step();
      chk("mid_rst_hold_cnt", busy_cnt, 6'd0);
      idle();
      @(negedge clk);
      reset = 1'b1;
      #1;

      // Full fill 1..31 saturates at 31 with no wrap.
      for (int i = 1; i <= 31; i++) begin
         issue_valid = 1'b1; issue_rd = 5'(i);
         step();
         chk($sformatf("fill_cnt_%0d", i), busy_cnt, 32'(i));
      end
      issue_rd = 5'd3;
      #1;
      chk("full_ready3", issue_ready, 1'b0);
      step();
      idle();
      #1;
      chk("full_cnt_hold", busy_cnt, 6'd31);
      rs1 = 5'd31;
      #1;
      chk("full_busy31", busy1, 1'b1);

      // One writeback from the full state decrements the count.
      wb_valid = 1'b1; wb_rd = 5'd31; wb_data = 32'hCAFEF00D;
      step();
      idle();
      #1;
      chk("full_wb_cnt", busy_cnt, 6'd30);
      chk("full_wb_rd1", rd1, 32'hCAFEF00D);
      chk("full_wb_err", wb_err, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL expose the following ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs1  in  5  read port 1 register index.
- rs2  in  5  read port 2 register index.
- rd1  out  32  read port 1 data.
- rd2  out  32  read port 2 data.
- busy1  out  1  register rs1 has a pending write.
- busy2  out  1  register rs2 has a pending write.
- issue_valid  in  1  request to reserve destination issue_rd.
- issue_rd  in  5  destination index being reserved.
- issue_ready  out  1  reservation of issue_rd is accepted this cycle.
- wb_valid  in  1  writeback strobe.
- wb_rd  in  5  writeback destination index.
- wb_data  in  32  writeback data.
- busy_cnt  out  6  number of registers currently busy (0..31).
- wb_err  out  1  sticky flag: writeback to a non-busy register occurred.

Function
REQ-002 The block SHALL hold 32 x 32-bit registers with one busy bit each; register 0 SHALL always read 0, never be written, and never become busy.
REQ-003 rd1/rd2 SHALL be combinational from stored state and rs1/rs2; zero cycles of read latency.
REQ-004 A write SHALL occur at the clock edge when wb_valid=1 and wb_rd!=0; the new value SHALL be visible on the read ports from the next cycle.
REQ-005 issue_ready SHALL be 1 when issue_rd=0, or busy[issue_rd]=0, or (wb_valid=1 and wb_rd=issue_rd).
REQ-006 busy[issue_rd] SHALL be set at the edge when issue_valid=1, issue_ready=1 and issue_rd!=0; issue_valid with issue_ready=0 SHALL change no state.
REQ-007 busy[wb_rd] SHALL be cleared at the edge when wb_valid=1 and wb_rd!=0.
REQ-008 If an accepted issue and a writeback target the same index in the same cycle, the data SHALL be written and the busy bit SHALL end set (set wins).
REQ-009 busy_cnt SHALL equal the population count of busy[31:1] at all times; it SHALL be a registered counter updated by +1, -1, or 0 per edge, never wrapping.
REQ-010 A writeback to wb_rd!=0 with busy[wb_rd]=0 and no same-cycle issue to that index SHALL still write the data, SHALL leave busy_cnt unchanged, and SHALL set wb_err from the next cycle until reset.
REQ-011 wb_valid with wb_rd=0 SHALL have no effect on state and SHALL NOT set wb_err.

Reset
REQ-012 With reset=0, all registers SHALL be 0, all busy bits 0, busy_cnt=0 and wb_err=0, immediately and independent of clk.
REQ-013 Any writeback or issue in flight when reset asserts SHALL be discarded; no state change SHALL occur while reset=0.
REQ-014 After reset deasserts, the first state update SHALL occur at the first rising clk edge with reset=1.

Configuration
REQ-015 With macro REGFILE_BYPASS_EN defined: when wb_valid=1, wb_rd!=0 and rsN=wb_rd, rdN SHALL equal wb_data and busyN SHALL be 0 in that same cycle.
REQ-016 Without REGFILE_BYPASS_EN: rdN SHALL show only stored data and busyN SHALL show the stored busy bit; the written value and the cleared busy bit become visible the next cycle.

Verification
REQ-017 Reset, then rs1=0, rs2=31 -> rd1=0, rd2=0, busy1=busy2=0, busy_cnt=0, wb_err=0.
REQ-018 Issue rd=5; next cycle issue rd=5 again -> issue_ready=0, busy_cnt stays 1; then wb rd=5 data 0xDEADBEEF -> busy_cnt=0; next cycle rs1=5 gives 0xDEADBEEF.
REQ-019 busy[7]=1; same cycle issue rd=7 and wb rd=7 data 0x12345678 -> issue_ready=1, busy[7] stays 1, busy_cnt unchanged, next-cycle rd1(rs1=7)=0x12345678.
REQ-020 wb rd=9 data 0xA5A5A5A5 with busy[9]=0 -> register 9 updated, busy_cnt unchanged, wb_err=1 next cycle and held; wb rd=0 data 0xFFFFFFFF -> rd1(rs1=0)=0.
REQ-021 Issue rd=1..31 on consecutive cycles -> busy_cnt reaches 31 with no wrap; assert reset mid-sequence -> busy_cnt=0 and all busy bits 0 immediately.
REQ-022 rs2=12 while wb rd=12 data 0x0BADF00D -> with REGFILE_BYPASS_EN, rd2=0x0BADF00D and busy2=0 same cycle; without it, rd2 shows the old value and matches 0x0BADF00D next cycle.
